// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle for clk_div_ctrl. The optional period_cnt output
// exists only when CLK_DIV_CTRL_PERIOD_CNT_EN is defined.
interface clk_div_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             div_ack;
    logic             clk_div;
    logic             tick;
    logic             busy;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [15:0]      period_cnt;

    modport master (
        output enable, div_val, div_load,
        input  div_ack, clk_div, tick, busy, period_cnt
    );
    modport slave (
        input  enable, div_val, div_load,
        output div_ack, clk_div, tick, busy, period_cnt
    );
`else
    modport master (
        output enable, div_val, div_load,
        input  div_ack, clk_div, tick, busy
    );
    modport slave (
        input  enable, div_val, div_load,
        output div_ack, clk_div, tick, busy
    );
`endif
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time fabric clock divider controller: glitch-free ratio changes at period
// boundaries and clean start/stop. Optional macro: CLK_DIV_CTRL_PERIOD_CNT_EN.
module clk_div_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_div_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] ratio, ratio_nx;
    logic [CNT_W-1:0] shadow, shadow_nx;
    logic             pending, pending_nx;
    logic             clk_div_q, clk_div_nx;
    logic             tick_q, tick_nx;
    logic             ack_q, ack_nx;

    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] eff_shadow;
    logic             eff_pending;
    logic             at_end;
    logic             run_nx;
    logic [CNT_W-1:0] half_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ratio     <= CNT_W'(DEFAULT_DIV);
            shadow    <= '0;
            pending   <= 1'b0;
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ratio     <= ratio_nx;
            shadow    <= shadow_nx;
            pending   <= pending_nx;
            clk_div_q <= clk_div_nx;
            tick_q    <= tick_nx;
            ack_q     <= ack_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ratio_nx   = ratio;
        shadow_nx  = shadow;
        pending_nx = pending;
        ack_nx     = 1'b0;

        load_val    = (bus.div_val < CNT_W'(2)) ? CNT_W'(2) : bus.div_val;
        // A load in the tick cycle joins the pending slot so it lands on this wrap.
        eff_pending = pending | bus.div_load;
        eff_shadow  = bus.div_load ? load_val : shadow;
        at_end      = (cnt == ratio - CNT_W'(1));

        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (bus.div_load) begin
                    ratio_nx = load_val;
                    ack_nx   = 1'b1;
                end
                if (bus.enable)
                    state_nx = RUN;
            end
            RUN, STOP_PEND: begin
                if (at_end) begin
                    cnt_nx = '0;
                    if (eff_pending) begin
                        ratio_nx   = eff_shadow;
                        pending_nx = 1'b0;
                        ack_nx     = 1'b1;
                    end
                    state_nx = bus.enable ? RUN : IDLE;
                end else begin
                    cnt_nx     = cnt + CNT_W'(1);
                    shadow_nx  = eff_shadow;
                    pending_nx = eff_pending;
                    state_nx   = bus.enable ? RUN : STOP_PEND;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Outputs are registered, so derive them from the values the counter takes next.
        run_nx     = (state_nx != IDLE);
        half_nx    = {1'b0, ratio_nx[CNT_W-1:1]} + {{(CNT_W-1){1'b0}}, ratio_nx[0]};
        clk_div_nx = run_nx && (cnt_nx < half_nx);
        tick_nx    = run_nx && (cnt_nx == ratio_nx - CNT_W'(1));
    end

    assign bus.clk_div = clk_div_q;
    assign bus.tick    = tick_q;
    assign bus.div_ack = ack_q;
    assign bus.busy    = (state != IDLE);

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [15:0] period_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            period_cnt_q <= '0;
        else if (tick_q)
            period_cnt_q <= period_cnt_q + 16'd1;
    end

    assign bus.period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a behavioural model pushes the expected
// outputs for each driven cycle; they are popped and compared after the edge.
module tb_clk_div_ctrl;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clk_div_ctrl_if #(.CNT_W(CNT_W)) bus ();

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        clk_div;
        logic        tick;
        logic        ack;
        logic        busy;
        logic [15:0] pcnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ack_seen = 0;

    // Reference model state
    bit   m_run;
    int   m_pos;
    int   m_n;
    int   m_sh;
    bit   m_pend;
    bit   m_ack;
    bit   m_tick;
    int   m_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_n = 4; m_sh = 0; m_pend = 0; m_ack = 0; m_tick = 0; m_pc = 0;
    endtask

    task automatic model_step(input bit en, input bit ld, input int v);
        int   lv;
        exp_t e;
        lv = (v < 2) ? 2 : v;
        if (m_tick) m_pc = (m_pc + 1) % 65536;
        m_ack = 0;
        if (!m_run) begin
            if (ld) begin m_n = lv; m_ack = 1; end
            if (en) begin m_run = 1; m_pos = 0; end
        end else begin
            if (ld) begin m_sh = lv; m_pend = 1; end
            if (m_pos == m_n - 1) begin
                m_pos = 0;
                if (m_pend) begin m_n = m_sh; m_pend = 0; m_ack = 1; end
                if (!en) m_run = 0;
            end else begin
                m_pos++;
            end
        end
        m_tick    = m_run && (m_pos == m_n - 1);
        e.clk_div = m_run && (m_pos < (m_n + 1) / 2);
        e.tick    = m_tick;
        e.ack     = m_ack;
        e.busy    = m_run;
        e.pcnt    = 16'(m_pc);
        sb_q.push_back(e);
    endtask

    task automatic step(input bit en, input bit ld, input int v);
        exp_t e;
        bus.enable   = en;
        bus.div_load = ld;
        bus.div_val  = 16'(v);
        model_step(en, ld, v);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("clk_div", 32'(bus.clk_div), 32'(e.clk_div));
            check("tick",    32'(bus.tick),    32'(e.tick));
            check("div_ack", 32'(bus.div_ack), 32'(e.ack));
            check("busy",    32'(bus.busy),    32'(e.busy));
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
            check("period_cnt", 32'(bus.period_cnt), 32'(e.pcnt));
`endif
        end
        if (bus.div_ack) ack_seen++;
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) step(en, 1'b0, 0);
    endtask

    task automatic run_to_pos(input int k);
        for (int i = 0; i < 70000 && m_pos != k; i++) step(1'b1, 1'b0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clk_div"}, 32'(bus.clk_div), 32'd0);
        check({tag, "_tick"},    32'(bus.tick),    32'd0);
        check({tag, "_ack"},     32'(bus.div_ack), 32'd0);
        check({tag, "_busy"},    32'(bus.busy),    32'd0);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        check({tag, "_pcnt"},    32'(bus.period_cnt), 32'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acks_before;
        bus.enable = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
        rst_n = 1'b0;
        model_reset();
        #23;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Default ratio 4: 1,1,0,0 with tick on the second low cycle
        run(13, 1'b1);
        run(6, 1'b0);

        // Idle load of 5, then run
        step(1'b0, 1'b1, 5);
        run(16, 1'b1);
        run(7, 1'b0);

        // Back to 4, load 6 at cnt=1 mid-run
        step(1'b0, 1'b1, 4);
        run(2, 1'b1);
        run_to_pos(1);
        step(1'b1, 1'b1, 6);
        run(18, 1'b1);

        // Two loads before the boundary: one ack, last value wins
        run_to_pos(0);
        acks_before = ack_seen;
        step(1'b1, 1'b1, 8);
        step(1'b1, 1'b1, 10);
        run(24, 1'b1);
        check("single_ack", 32'(ack_seen - acks_before), 32'd1);

        // Clamp of 0 to 2
        step(1'b1, 1'b1, 0);
        run(16, 1'b1);

        // Ratio 6, drop enable at cnt=2
        step(1'b1, 1'b1, 6);
        run(8, 1'b1);
        run_to_pos(2);
        run(7, 1'b0);

        // Re-enable during stop pending: no gap
        run(3, 1'b1);
        run(2, 1'b0);
        run(8, 1'b1);

        // Load in the tick cycle applies at the immediate wrap
        run_to_pos(m_n - 1);
        step(1'b1, 1'b1, 3);
        run(10, 1'b1);

        // Pending ratio carried into IDLE through STOP_PEND
        run_to_pos(0);
        step(1'b0, 1'b1, 7);
        run(6, 1'b0);
        run(16, 1'b1);

        // Async reset mid-period with a ratio pending
        run_to_pos(1);
        step(1'b1, 1'b1, 9);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        bus.enable = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
        sb_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        acks_before = ack_seen;
        run(12, 1'b1);
        check("no_ack_after_rst", 32'(ack_seen - acks_before), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, int'($urandom_range(0, 12)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
